// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud defaults for the TX and RX ends
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam int DEFAULT_CLK_FREQ     = 100_000_000;
    localparam int DEFAULT_BAUD         = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD;

    // Keeps counters at least one bit wide when a divider of 1 is requested.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - per-bit cycle counter emitting bit_tick on the last cycle of each bit
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with valid/ready input; UART_TX_PARITY_EN adds a parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic accept;
    logic bit_tick;

    assign accept = valid && ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (accept),
        .en_i       (state_q != S_IDLE),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shreg_d = data;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Bit 1 of the current register becomes bit 0 after the shift.
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    if (idx_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with line-decoding scoreboard
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FL = FBITS * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready, tx, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]       d;
        logic [FBITS-1:0] frame;
    } vec_t;

    vec_t             vecs[4];
    logic [FBITS-1:0] ff_frame;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD   (1'b0)
`endif
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Line receiver model: samples mid-bit, compares decoded bytes against the expected queue.
    initial begin
        bit               m_active = 1'b0;
        int               m_cnt    = 0;
        logic [FBITS-1:0] mframe   = '0;
        logic [7:0]       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 1'b0;
            end else begin
                if (!m_active && tx == 1'b0) begin
                    m_active = 1'b1;
                    m_cnt    = 0;
                end else if (m_active) begin
                    m_cnt++;
                end
                if (m_active && (m_cnt % CPB) == CPB / 2) begin
                    mframe[m_cnt / CPB] = tx;
                    if (m_cnt / CPB == FBITS - 1) begin
                        m_active = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_unexpected: got frame data 0x%0h expected no frame", mframe[8:1]);
                        end else begin
                            e = exp_q.pop_front();
                            check("rx_data", 64'(mframe[8:1]), 64'(e));
                            check("rx_stop", 64'(mframe[FBITS-1]), 64'd1);
                        end
                    end
                end
            end
        end
    end

    task automatic send_line(input logic [7:0] d, input logic [FBITS-1:0] frame,
                             input bit inject, input string nm);
        logic [FL-1:0] got;
        logic [FL-1:0] exp_line;
        int ready_low = 0;
        int bad_busy  = 0;
        int done_seen = 0;
        @(negedge clk);
        check({nm, "_pre_idle"}, 64'({tx, ready}), 64'b11);
        data  = d;
        valid = 1'b1;
        exp_q.push_back(d);
        @(posedge clk);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            if (c == 0) valid = 1'b0;
            if (inject && c == 15) begin
                valid = 1'b1;
                data  = 8'h00;
            end
            if (inject && c == 16) valid = 1'b0;
            got[c]      = tx;
            exp_line[c] = frame[c / CPB];
            if (ready !== 1'b0) ready_low = ready_low;
            else ready_low++;
            if (busy !== ~ready) bad_busy++;
            if (done !== 1'b0) done_seen++;
        end
        check({nm, "_line"}, 64'(got), 64'(exp_line));
        check({nm, "_ready_low"}, 64'(ready_low), 64'(FL));
        check({nm, "_busy_inv"}, 64'(bad_busy), 64'd0);
        check({nm, "_done_early"}, 64'(done_seen), 64'd0);
        @(negedge clk);
        check({nm, "_end"}, 64'({tx, ready, busy, done}), 64'b1101);
        @(negedge clk);
        check({nm, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int            bad;
        int            n;
        int            t[3];
        logic [7:0]    b2b[3];

`ifdef UART_TX_PARITY_EN
        vecs[0]  = '{d: 8'h59, frame: 11'b1_0_01011001_0};
        vecs[1]  = '{d: 8'h3C, frame: 11'b1_0_00111100_0};
        vecs[2]  = '{d: 8'h01, frame: 11'b1_1_00000001_0};
        vecs[3]  = '{d: 8'h80, frame: 11'b1_1_10000000_0};
        ff_frame = 11'b1_0_11111111_0;
`else
        vecs[0]  = '{d: 8'h59, frame: 10'b1_01011001_0};
        vecs[1]  = '{d: 8'h3C, frame: 10'b1_00111100_0};
        vecs[2]  = '{d: 8'h01, frame: 10'b1_00000001_0};
        vecs[3]  = '{d: 8'h80, frame: 10'b1_10000000_0};
        ff_frame = 10'b1_11111111_0;
`endif
        b2b[0] = 8'h59;
        b2b[1] = 8'hBA;
        b2b[2] = 8'hBF;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({tx, ready, busy, done}), 64'b1100);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({tx, ready, busy, done} !== 4'b1100) bad++;
        end
        check("idle_100", 64'(bad), 64'd0);

        for (int i = 0; i < 4; i++) begin
            send_line(vecs[i].d, vecs[i].frame, 1'b0, $sformatf("vec%0d", i));
        end

        send_line(8'hFF, ff_frame, 1'b1, "ignore_ff");
        bad = 0;
        repeat (2 * FL) begin
            @(negedge clk);
            if ({tx, ready} !== 2'b11) bad++;
        end
        check("no_second_frame", 64'(bad), 64'd0);

        data  = b2b[0];
        valid = 1'b1;
        exp_q.push_back(b2b[0]);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("b2b_wait%0d", i), 64'(n < 200), 64'd1);
            t[i] = cyc;
            @(posedge clk);
            @(negedge clk);
            if (i < 2) begin
                data = b2b[i + 1];
                exp_q.push_back(b2b[i + 1]);
            end else begin
                valid = 1'b0;
            end
        end
        check("b2b_gap1", 64'(t[1] - t[0]), 64'(FL + 1));
        check("b2b_gap2", 64'(t[2] - t[1]), 64'(FL + 1));
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", 64'(n < 200), 64'd1);
        repeat (3) @(negedge clk);

        data  = 8'hA5;
        valid = 1'b1;
        @(posedge clk);
        repeat (5 * CPB + 2) @(negedge clk);
        valid = 1'b0;
        check("a5_bit4_low", 64'(tx), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 64'({tx, ready, busy, done}), 64'b1100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", 64'({tx, ready, busy, done}), 64'b1100);
        send_line(vecs[1].d, vecs[1].frame, 1'b0, "after_rst_3c");

        repeat (20) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
